// File: rtl/calc_display_ctrl.sv
// rtl/calc_display_ctrl.sv - binary-to-BCD display controller with 4-digit multiplexed scan
module calc_display_ctrl #(
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 10_000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  output logic             value_ready,
  output logic             busy,
  output logic             overflow,
  output logic [3:0]       an,
  output logic [3:0]       digit
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [15:0]      bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             run_q, run_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       nib;
  logic             blank;
  logic             z1, z2, z3;

  // run_q keeps value_ready low until the first edge after reset is released
  assign run_d       = 1'b1;
  assign value_ready = (state_q == IDLE) && run_q;
  assign busy        = (state_q == CONV) || (state_q == COMMIT);
  assign overflow    = ovf_q;
  assign an          = an_q;
  assign digit       = digit_q;

  // State register plus datapath, scan and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      run_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1111;
      digit_q    <= 4'h0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      run_q      <= run_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
    end
  end

  // Conversion FSM: accept, double-dabble one bit per cycle, commit to the display register
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    bcd_adj    = bcd_q;
    case (state_q)
      IDLE: begin
        if (value_valid && value_ready) begin
          shreg_d    = value;
          bcd_d      = '0;
          ovf_pend_d = (32'(value) > 32'd9999);
          cnt_d      = CW'(WIDTH);
          state_d    = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < 4; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        // Bits leaving the top of the accumulator are dropped; overflow is tracked by ovf_pend
        bcd_d   = {bcd_adj[14:0], shreg_q[WIDTH-1]};
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running prescaler advancing the scan index on each wrap
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Anode/digit selection for the current scan slot, with leading-zero blanking and overflow override
  always_comb begin
    z3 = (disp_q[15:12] == 4'h0);
    z2 = z3 && (disp_q[11:8] == 4'h0);
    z1 = z2 && (disp_q[7:4] == 4'h0);
    nib   = disp_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd0: nib = disp_q[3:0];
      2'd1: begin nib = disp_q[7:4];   blank = z1; end
      2'd2: begin nib = disp_q[11:8];  blank = z2; end
      default: begin nib = disp_q[15:12]; blank = z3; end
    endcase
    if (BLANK_LZ == 0 || ovf_q) blank = 1'b0;
    an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    digit_d = ovf_q ? 4'hF : nib;
  end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// tb/tb_calc_display_ctrl.sv - directed self-checking bench for calc_display_ctrl
module tb_calc_display_ctrl;
  localparam int W  = 14;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] value = '0;
  logic         value_valid = 1'b0;
  logic         rdy_a, busy_a, ovf_a, rdy_b, busy_b, ovf_b;
  logic [3:0]   an_a, dig_a, an_b, dig_b;

  int vec  = 0;
  int errs = 0;
  int          lit_cnt [2][4];
  logic [15:0] dmask   [2][4];
  int          bad_an  [2];
  int          order_bad;
  int          exp_d   [4];
  int          exp_lit [4];

  always #5 clk = ~clk;

  calc_display_ctrl #(.WIDTH(W), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
    .value_ready(rdy_a), .busy(busy_a), .overflow(ovf_a), .an(an_a), .digit(dig_a));

  calc_display_ctrl #(.WIDTH(W), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
    .value_ready(rdy_b), .busy(busy_b), .overflow(ovf_b), .an(an_b), .digit(dig_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic observe(input int n);
    int prev;
    int s;
    logic [3:0] a, d;
    for (int u = 0; u < 2; u++) begin
      bad_an[u] = 0;
      for (int k = 0; k < 4; k++) begin
        lit_cnt[u][k] = 0;
        dmask[u][k]   = '0;
      end
    end
    order_bad = 0;
    prev = -1;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        a = (u == 0) ? an_a : an_b;
        d = (u == 0) ? dig_a : dig_b;
        s = slot_of(a);
        if (s >= 0) begin
          lit_cnt[u][s]++;
          dmask[u][s][d] = 1'b1;
        end else if (a != 4'b1111) begin
          bad_an[u]++;
        end
        if (u == 0) begin
          if (s >= 0 && prev >= 0 && s != prev && s != (prev + 1) % 4) order_bad++;
          prev = s;
        end
      end
    end
  endtask

  task automatic send(input logic [W-1:0] v);
    int n;
    n = 0;
    while (!rdy_a && n < 50) begin
      tick();
      n++;
    end
    vec++;
    if (rdy_a !== 1'b1) begin
      errs++;
      $display("FAIL send_ready: value_ready=%b expected 1 within 50 cycles", rdy_a);
    end
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    while (busy_a && nbusy < 100) begin
      nbusy++;
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (21) tick();
    #2 rst = 1'b1;
    #1;
    vec++; if (an_a !== 4'b1111) begin errs++; $display("FAIL reset_an: got %b expected 1111", an_a); end
    vec++; if (dig_a !== 4'h0) begin errs++; $display("FAIL reset_digit: got %h expected 0", dig_a); end
    vec++; if (ovf_a !== 1'b0) begin errs++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
    vec++; if (rdy_a !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b expected 0", rdy_a); end
    vec++; if (busy_a !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    @(posedge clk);
    #1 rst = 1'b0;
    vec++; if (rdy_a !== 1'b0) begin errs++; $display("FAIL reset_ready_release: got %b expected 0", rdy_a); end
    tick();
    vec++; if (rdy_a !== 1'b1) begin errs++; $display("FAIL reset_ready_after: got %b expected 1", rdy_a); end
    vec++; if (an_a !== 4'b1110) begin errs++; $display("FAIL reset_first_scan_an: got %b expected 1110", an_a); end
    vec++; if (dig_a !== 4'h0) begin errs++; $display("FAIL reset_first_scan_digit: got %h expected 0", dig_a); end
  endtask

  task automatic test_convert();
    int nb;
    send(14'd1234);
    wait_done(nb);
    vec++; if (nb !== 15) begin errs++; $display("FAIL conv_busy_cycles: got %0d expected 15", nb); end
    vec++; if (rdy_a !== 1'b1) begin errs++; $display("FAIL conv_ready_after: got %b expected 1", rdy_a); end
    vec++; if (ovf_a !== 1'b0) begin errs++; $display("FAIL conv_overflow: got %b expected 0", ovf_a); end
    tick();
    observe(32);
    exp_d = '{4, 3, 2, 1};
    exp_lit = '{1, 1, 1, 1};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== (exp_lit[k] ? 8 : 0) || dmask[0][k] !== (exp_lit[k] ? (16'h1 << exp_d[k]) : 16'h0)) begin
        errs++;
        $display("FAIL conv_1234 slot %0d: lit %0d digits %h expected lit %0d digit %0d", k, lit_cnt[0][k], dmask[0][k], exp_lit[k] * 8, exp_d[k]);
      end
    end
    vec++; if (order_bad !== 0) begin errs++; $display("FAIL conv_scan_order: got %0d bad steps expected 0", order_bad); end
    vec++; if (bad_an[0] !== 0) begin errs++; $display("FAIL conv_an_pattern: got %0d bad anodes expected 0", bad_an[0]); end
  endtask

  task automatic test_blanking();
    int nb;
    send(14'd7);
    wait_done(nb);
    tick();
    observe(32);
    exp_d = '{7, 0, 0, 0};
    exp_lit = '{1, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== (exp_lit[k] ? 8 : 0) || dmask[0][k] !== (exp_lit[k] ? (16'h1 << exp_d[k]) : 16'h0)) begin
        errs++;
        $display("FAIL blank_7 slot %0d: lit %0d digits %h expected lit %0d digit %0d", k, lit_cnt[0][k], dmask[0][k], exp_lit[k] * 8, exp_d[k]);
      end
    end
    send(14'd1000);
    observe(14);
    vec++;
    if (dmask[0][0] !== 16'h0080 || lit_cnt[0][1] !== 0 || lit_cnt[0][2] !== 0 || lit_cnt[0][3] !== 0) begin
      errs++;
      $display("FAIL hold_during_conv: slot0 digits %h lit1..3 %0d/%0d/%0d expected 0080 and 0/0/0", dmask[0][0], lit_cnt[0][1], lit_cnt[0][2], lit_cnt[0][3]);
    end
    wait_done(nb);
    tick();
    observe(32);
    exp_d = '{0, 0, 0, 1};
    exp_lit = '{1, 1, 1, 1};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== (exp_lit[k] ? 8 : 0) || dmask[0][k] !== (exp_lit[k] ? (16'h1 << exp_d[k]) : 16'h0)) begin
        errs++;
        $display("FAIL blank_1000 slot %0d: lit %0d digits %h expected lit %0d digit %0d", k, lit_cnt[0][k], dmask[0][k], exp_lit[k] * 8, exp_d[k]);
      end
    end
  endtask

  task automatic test_zero();
    int nb;
    send(14'd0);
    wait_done(nb);
    tick();
    observe(32);
    exp_lit = '{1, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== (exp_lit[k] ? 8 : 0) || dmask[0][k] !== (exp_lit[k] ? 16'h0001 : 16'h0)) begin
        errs++;
        $display("FAIL zero_blank slot %0d: lit %0d digits %h expected lit %0d digit 0", k, lit_cnt[0][k], dmask[0][k], exp_lit[k] * 8);
      end
      vec++;
      if (lit_cnt[1][k] !== 8 || dmask[1][k] !== 16'h0001) begin
        errs++;
        $display("FAIL zero_noblank slot %0d: lit %0d digits %h expected lit 8 digit 0", k, lit_cnt[1][k], dmask[1][k]);
      end
    end
  endtask

  task automatic test_overflow();
    int nb;
    send(14'd12000);
    wait_done(nb);
    vec++; if (ovf_a !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b expected 1", ovf_a); end
    tick();
    observe(32);
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== 8 || dmask[0][k] !== 16'h8000) begin
        errs++;
        $display("FAIL ovf_digits slot %0d: lit %0d digits %h expected lit 8 digit F", k, lit_cnt[0][k], dmask[0][k]);
      end
    end
    vec++; if (ovf_a !== 1'b1) begin errs++; $display("FAIL ovf_hold: got %b expected 1", ovf_a); end
    send(14'd42);
    wait_done(nb);
    vec++; if (ovf_a !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b expected 0", ovf_a); end
    tick();
    observe(32);
    exp_d = '{2, 4, 0, 0};
    exp_lit = '{1, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== (exp_lit[k] ? 8 : 0) || dmask[0][k] !== (exp_lit[k] ? (16'h1 << exp_d[k]) : 16'h0)) begin
        errs++;
        $display("FAIL ovf_then_42 slot %0d: lit %0d digits %h expected lit %0d digit %0d", k, lit_cnt[0][k], dmask[0][k], exp_lit[k] * 8, exp_d[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    send(14'd1234);
    tick();
    value       = 14'd9999;
    value_valid = 1'b1;
    vec++; if (rdy_a !== 1'b0) begin errs++; $display("FAIL b2b_ready_in_conv: got %b expected 0", rdy_a); end
    tick();
    value_valid = 1'b0;
    wait_done(nb);
    vec++; if (nb !== 13) begin errs++; $display("FAIL b2b_busy_remaining: got %0d expected 13", nb); end
    tick();
    vec++; if (busy_a !== 1'b0) begin errs++; $display("FAIL b2b_no_queue: busy got %b expected 0", busy_a); end
    observe(32);
    exp_d = '{4, 3, 2, 1};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== 8 || dmask[0][k] !== (16'h1 << exp_d[k])) begin
        errs++;
        $display("FAIL b2b_ignored slot %0d: lit %0d digits %h expected lit 8 digit %0d", k, lit_cnt[0][k], dmask[0][k], exp_d[k]);
      end
    end
    send(14'd5678);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    vec++; if (busy_a !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
    vec++; if (ovf_a !== 1'b0) begin errs++; $display("FAIL abort_overflow: got %b expected 0", ovf_a); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    vec++; if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin errs++; $display("FAIL abort_idle: ready %b busy %b expected 1 0", rdy_a, busy_a); end
    observe(32);
    exp_lit = '{1, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (lit_cnt[0][k] !== (exp_lit[k] ? 8 : 0) || dmask[0][k] !== (exp_lit[k] ? 16'h0001 : 16'h0)) begin
        errs++;
        $display("FAIL abort_display slot %0d: lit %0d digits %h expected lit %0d digit 0", k, lit_cnt[0][k], dmask[0][k], exp_lit[k] * 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_zero();
    test_overflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
